jk_bank_scheduler: RTL and testbench

Shared controller for a WIDTH-bit bank of JK flip-flop cells. Two requesters submit JK command masks through valid/ready handshakes, and a round-robin arbiter grants one command at a time. The granted command is applied to every bit with standard JK semantics for a programmable number of consecutive clock cycles, and completion is reported with a tagged one-cycle pulse. The block sits between software-visible command ports and the flag/state register bank built from JK cells.

---
 rtl/jk_bank_scheduler_if.sv | 39 +++
 rtl/jk_bank_scheduler.sv | 98 +++++++++
 tb/tb_jk_bank_scheduler.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_scheduler_if.sv
// Command/status bundle between two JK requesters and the bank scheduler.
// Latency: none, this is wiring only.
// Backpressure: each requester holds valid and its payload until the scheduler raises ready.
interface jk_bank_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  // requester A command port
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_j;
  logic [WIDTH-1:0] a_k;
  logic [CNT_W-1:0] a_rep;
  // requester B command port
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_j;
  logic [WIDTH-1:0] b_k;
  logic [CNT_W-1:0] b_rep;
  // bank state and completion status
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             done_id;

  modport master (
    output a_valid, a_j, a_k, a_rep,
    output b_valid, b_j, b_k, b_rep,
    input  a_ready, b_ready,
    input  q, busy, done, done_id
  );

  modport slave (
    input  a_valid, a_j, a_k, a_rep,
    input  b_valid, b_j, b_k, b_rep,
    output a_ready, b_ready,
    output q, busy, done, done_id
  );
endinterface

// File: rtl/jk_bank_scheduler.sv
// Round-robin scheduler applying granted JK masks to a WIDTH-bit bank for rep+1 cycles.
// Latency: q updates on the rep+1 edges after accept; done pulses the cycle after the last apply.
// Backpressure: ready only in IDLE to the granted requester; one command in flight, rep+3 cycles each.
module jk_bank_scheduler #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  jk_bank_scheduler_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] cmd_j;
  logic [WIDTH-1:0] cmd_k;
  logic [CNT_W-1:0] count;
  logic             owner;
  logic             rr_last;

  logic             grant_a;
  logic             grant_b;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] q_next;

  // Lone requester wins; on a tie the requester not served last wins (rr_last: 0=A, 1=B).
  // Ready is also gated by reset so it drops the moment reset asserts.
  always_comb begin
    grant_a    = bus.a_valid & (~bus.b_valid | rr_last);
    grant_b    = bus.b_valid & (~bus.a_valid | ~rr_last);
    can_accept = (state == ST_IDLE) & ~clr & reset;
    accept     = can_accept & (grant_a | grant_b);
  end

  // Per-bit JK rule: 00 hold, 01 clear, 10 set, 11 toggle.
  always_comb begin
    q_next = (cmd_j & ~q_r) | (~cmd_k & q_r);
  end

  assign bus.a_ready = can_accept & grant_a;
  assign bus.b_ready = can_accept & grant_b;
  assign bus.q       = q_r;
  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = (state == ST_DONE);
  assign bus.done_id = (state == ST_DONE) ? owner : 1'b0;

  // Command FSM: latch on accept, apply rep+1 times, one DONE cycle; clr aborts without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      q_r     <= '0;
      cmd_j   <= '0;
      cmd_k   <= '0;
      count   <= '0;
      owner   <= 1'b0;
      rr_last <= 1'b1;
    end else if (clr) begin
      state <= ST_IDLE;
      q_r   <= '0;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_j   <= grant_b ? bus.b_j   : bus.a_j;
            cmd_k   <= grant_b ? bus.b_k   : bus.a_k;
            count   <= grant_b ? bus.b_rep : bus.a_rep;
            owner   <= grant_b;
            rr_last <= grant_b;
            state   <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          q_r <= q_next;
          // count==0 marks the final apply; stopping here avoids any wrap at the max repeat
          if (count == '0) begin
            state <= ST_DONE;
          end else begin
            count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Directed bench for jk_bank_scheduler: table of single commands plus hand sequences.
// Latency: drives at negedge, samples at negedge (away from the rising edge).
// Backpressure: requesters hold valid and payload until ready is seen.
module tb_jk_bank_scheduler;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic clr;
  int   n_checks = 0;
  int   n_fail = 0;

  jk_bank_scheduler_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  jk_bank_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic [7:0] j;
    logic [7:0] k;
    logic [3:0] rep;
    logic [7:0] q_exp;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] qtrace[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [7:0] j, input logic [7:0] k, input logic [3:0] rep);
    bus.a_valid = v; bus.a_j = j; bus.a_k = k; bus.a_rep = rep;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] j, input logic [7:0] k, input logic [3:0] rep);
    bus.b_valid = v; bus.b_j = j; bus.b_k = k; bus.b_rep = rep;
  endtask

  // Issue one command from the chosen requester (called at a negedge), follow it to idle.
  task automatic run_cmd(input logic sel, input logic [7:0] j, input logic [7:0] k, input logic [3:0] rep,
                         output logic acc, output int busy_cnt, output int done_cnt,
                         output int done_at, output logic done_id_seen);
    int t;
    acc = 1'b0; busy_cnt = 0; done_cnt = 0; done_at = -1; done_id_seen = 1'b0;
    if (sel) drive_b(1'b1, j, k, rep);
    else     drive_a(1'b1, j, k, rep);
    #1;
    t = 0;
    while (!(sel ? bus.b_ready : bus.a_ready) && t < 20) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 20) begin
      drive_a(1'b0, 8'h00, 8'h00, 4'd0);
      drive_b(1'b0, 8'h00, 8'h00, 4'd0);
      @(negedge clk);
    end else begin
      acc = 1'b1;
      @(posedge clk);
      for (int n = 0; n <= int'(rep) + 3; n++) begin
        @(negedge clk);
        if (n == 0) begin
          if (sel) drive_b(1'b0, j, k, rep);
          else     drive_a(1'b0, j, k, rep);
        end
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
          done_cnt++;
          done_at = n;
          done_id_seen = bus.done_id;
        end
        if (n >= 1 && n <= int'(rep) + 1) qtrace[n-1] = bus.q;
      end
    end
  endtask

  // Global time bound so a stuck design still ends the run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       acc;
    logic       did;
    int         bc, dc, da;
    int         ndone;
    logic [7:0] ids[4];
    logic [7:0] qs[4];

    // set/clear/hold/toggle vectors; q_exp chains from the previous entry starting at q=0
    vecs[0] = '{1'b0, 8'h3C, 8'hC3, 4'd0,  8'h3C};
    vecs[1] = '{1'b0, 8'hF0, 8'h0F, 4'd0,  8'hF0};
    vecs[2] = '{1'b1, 8'hFF, 8'hFF, 4'd0,  8'h0F};
    vecs[3] = '{1'b1, 8'h00, 8'h00, 4'd3,  8'h0F};
    vecs[4] = '{1'b0, 8'hAA, 8'h00, 4'd1,  8'hAF};
    vecs[5] = '{1'b1, 8'h00, 8'h81, 4'd0,  8'h2E};
    vecs[6] = '{1'b0, 8'h0F, 8'h0F, 4'd15, 8'h2E};
    vecs[7] = '{1'b1, 8'h0F, 8'h0F, 4'd14, 8'h21};
    vecs[8] = '{1'b0, 8'h12, 8'h34, 4'd2,  8'h13};

    // ---- reset state, with A requesting during reset ----
    reset = 1'b0; clr = 1'b0;
    drive_a(1'b1, 8'hFF, 8'hFF, 4'd0);
    drive_b(1'b0, 8'h00, 8'h00, 4'd0);
    #1;
    check("reset a_ready", 32'(bus.a_ready), 32'h0);
    check("reset q", 32'(bus.q), 32'h0);
    check("reset busy", 32'(bus.busy), 32'h0);
    check("reset done", 32'(bus.done), 32'h0);
    repeat (2) @(negedge clk);
    drive_a(1'b0, 8'h00, 8'h00, 4'd0);
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("quiescent", {28'h0, bus.a_ready, bus.b_ready, bus.busy, bus.done}, 32'h0);
      check("quiescent q", 32'(bus.q), 32'h0);
    end

    // ---- reset asserted mid-APPLY ----
    drive_a(1'b1, 8'hFF, 8'hFF, 4'd5);
    @(posedge clk);
    @(negedge clk);
    drive_a(1'b0, 8'hFF, 8'hFF, 4'd5);
    @(negedge clk);
    check("pre-reset apply q", 32'(bus.q), 32'hFF);
    drive_b(1'b1, 8'h01, 8'h00, 4'd0);
    #2 reset = 1'b0;
    #1;
    check("async reset q", 32'(bus.q), 32'h0);
    check("async reset busy", 32'(bus.busy), 32'h0);
    check("async reset done", 32'(bus.done), 32'h0);
    check("async reset b_ready", 32'(bus.b_ready), 32'h0);
    @(negedge clk);
    drive_b(1'b0, 8'h00, 8'h00, 4'd0);
    reset = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      check("post-reset quiescent", {20'h0, bus.q, bus.a_ready, bus.b_ready, bus.busy, bus.done}, 32'h0);
    end

    // ---- toggle repeat from B, rep=2 ----
    run_cmd(1'b1, 8'hFF, 8'hFF, 4'd2, acc, bc, dc, da, did);
    check("toggle accept", 32'(acc), 32'h1);
    check("toggle q E1", 32'(qtrace[0]), 32'hFF);
    check("toggle q E2", 32'(qtrace[1]), 32'h00);
    check("toggle q E3", 32'(qtrace[2]), 32'hFF);
    check("toggle busy cycles", 32'(bc), 32'd4);
    check("toggle done count", 32'(dc), 32'd1);
    check("toggle done_id", 32'(did), 32'h1);

    // ---- synchronous clr back to zero ----
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr q", 32'(bus.q), 32'h0);

    // ---- table of single commands ----
    for (int v = 0; v < 9; v++) begin
      run_cmd(vecs[v].sel, vecs[v].j, vecs[v].k, vecs[v].rep, acc, bc, dc, da, did);
      check($sformatf("vec%0d accept", v), 32'(acc), 32'h1);
      check($sformatf("vec%0d busy cycles", v), 32'(bc), 32'(int'(vecs[v].rep) + 2));
      check($sformatf("vec%0d done count", v), 32'(dc), 32'd1);
      check($sformatf("vec%0d done slot", v), 32'(da), 32'(int'(vecs[v].rep) + 1));
      check($sformatf("vec%0d done_id", v), 32'(did), 32'(vecs[v].sel));
      check($sformatf("vec%0d q", v), 32'(bus.q), 32'(vecs[v].q_exp));
    end

    // ---- arbitration from reset: both valid, A toggles low nibble, B high nibble ----
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive_a(1'b1, 8'h0F, 8'h0F, 4'd0);
    drive_b(1'b1, 8'hF0, 8'hF0, 4'd0);
    ndone = 0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      check("single grant", 32'(bus.a_ready & bus.b_ready), 32'h0);
      if (bus.done) begin
        if (ndone < 4) begin
          ids[ndone] = {7'h0, bus.done_id};
          qs[ndone]  = bus.q;
        end
        ndone++;
      end
    end
    drive_a(1'b0, 8'h00, 8'h00, 4'd0);
    drive_b(1'b0, 8'h00, 8'h00, 4'd0);
    check("arb done count", 32'(ndone), 32'd4);
    if (ndone >= 4) begin
      check("arb id0", 32'(ids[0]), 32'h0);
      check("arb id1", 32'(ids[1]), 32'h1);
      check("arb id2", 32'(ids[2]), 32'h0);
      check("arb id3", 32'(ids[3]), 32'h1);
      check("arb q0", 32'(qs[0]), 32'h0F);
      check("arb q1", 32'(qs[1]), 32'hFF);
      check("arb q2", 32'(qs[2]), 32'hF0);
      check("arb q3", 32'(qs[3]), 32'h00);
    end
    repeat (3) @(negedge clk);
    check("arb idle busy", 32'(bus.busy), 32'h0);

    // ---- clr abort of A (rep=7) with B pending ----
    drive_a(1'b1, 8'h01, 8'h01, 4'd7);
    drive_b(1'b1, 8'h80, 8'h00, 4'd0);
    #1;
    check("abort a_ready", 32'(bus.a_ready), 32'h1);
    check("abort b_ready", 32'(bus.b_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive_a(1'b0, 8'h01, 8'h01, 4'd7);
    dc = 0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (bus.done) dc++;
      check($sformatf("abort q E%0d", n), 32'(bus.q), (n % 2 == 1) ? 32'h01 : 32'h00);
    end
    clr = 1'b1;
    @(negedge clk);
    if (bus.done) dc++;
    clr = 1'b0;
    check("abort q", 32'(bus.q), 32'h0);
    check("abort busy", 32'(bus.busy), 32'h0);
    drive_a(1'b1, 8'h01, 8'h01, 4'd7);
    #1;
    check("abort b wins", 32'(bus.b_ready), 32'h1);
    check("abort a waits", 32'(bus.a_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive_a(1'b0, 8'h00, 8'h00, 4'd0);
    drive_b(1'b0, 8'h00, 8'h00, 4'd0);
    check("abort b busy", 32'(bus.busy), 32'h1);
    did = 1'b0; ndone = 0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        did = bus.done_id;
        check("abort b q", 32'(bus.q), 32'h80);
      end
    end
    check("abort no done pulse", 32'(dc), 32'h0);
    check("abort b done count", 32'(ndone), 32'd1);
    check("abort b done_id", 32'(did), 32'h1);

    // ---- stall: A waits during B's APPLY, then a hold command ----
    drive_b(1'b1, 8'h55, 8'h00, 4'd3);
    #1;
    check("stall b_ready", 32'(bus.b_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    drive_b(1'b0, 8'h00, 8'h00, 4'd0);
    drive_a(1'b1, 8'h00, 8'h00, 4'd2);
    #1;
    check("stall a_ready E0", 32'(bus.a_ready), 32'h0);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      #1;
      check($sformatf("stall a_ready E%0d", n), 32'(bus.a_ready), 32'h0);
      check($sformatf("stall q E%0d", n), 32'(bus.q), 32'hD5);
    end
    check("stall b done", 32'({bus.done, bus.done_id}), 32'h3);
    @(negedge clk);
    #1;
    check("stall a_ready after", 32'(bus.a_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    drive_a(1'b0, 8'h00, 8'h00, 4'd0);
    ndone = 0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      check($sformatf("hold q E%0d", n), 32'(bus.q), 32'hD5);
      if (bus.done) begin
        ndone++;
        check("hold done_id", 32'(bus.done_id), 32'h0);
      end
    end
    check("hold done count", 32'(ndone), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
